sys1_rom_loader: RTL and testbench
==================================

Name: sys1_rom_loader

Overview:
- Sequences HPS ioctl downloads for the System 1 arcade core.
- Routes ROM bytes to the core ROM write port.
- Latches the SYSMODE header byte and the 8 DIP-switch bytes.
- Owns the core reset: holds the core in reset from power-up and during any ROM download, then releases it after a fixed stretch once the download is complete.
- Sits between hps_io and SEGASYSTEM1, and replaces the ad-hoc ioctl decode and reset OR in the top level.

Parameters:
- ROM_BYTES, 25'h20000: expected ROM image length in bytes. Writes at or above this address are errors.
- HOLD_CYCLES, 256: number of clk_sys cycles core_reset stays high after download end or after a user reset (1..65535).
- ROM_INDEX, 8'd0: ioctl_index value for the ROM image.
- HDR_INDEX, 8'd1: ioctl_index value for the SYSMODE header.
- DSW_INDEX, 8'd254: ioctl_index value for the DIP-switch block.

Ports:
- clk_sys, in, 1: system clock (48 MHz).
- reset, in, 1: asynchronous, active-high reset.
- user_rst, in, 1: menu/button reset request (level).
- ioctl_download, in, 1: download in progress.
- ioctl_wr, in, 1: byte strobe, one cycle.
- ioctl_index, in, 8: download target index.
- ioctl_addr, in, 25: byte address.
- ioctl_dout, in, 8: byte data.
- rom_we, out, 1: ROM write pulse to the core.
- rom_ad, out, 25: ROM write address.
- rom_dt, out, 8: ROM write data.
- sysmode, out, 8: [0] SYS1/SYS2, [1] H/V, [2] H256/H240.
- dsw, out, 64: DIP bytes; byte k is at [8k+7:8k].
- core_reset, out, 1: reset to SEGASYSTEM1.
- load_done, out, 1: a ROM image has loaded and the core is running.
- load_err, out, 1: sticky length/range error for the last ROM load.
- byte_count, out, 25: ROM bytes accepted in the current or last load.

Behaviour:
- Reset values:
  - State HALT, core_reset=1.
  - rom_we=0, rom_ad=0, rom_dt=0.
  - sysmode=8'h00, dsw=all 8'hFF.
  - load_done=0, load_err=0, byte_count=0.
- States:
  - HALT: no valid ROM. core_reset=1.
  - LOAD: ROM download active. core_reset=1.
  - HOLD: stretch counter running. core_reset=1.
  - RUN: core_reset=0.
- Download start: a rising edge of ioctl_download with ioctl_index==ROM_INDEX, from any state, moves to LOAD.
  - On entry: byte_count=0, load_err=0, load_done=0.
  - The index is sampled at the rise. Later index changes within that download are ignored.
- LOAD: each ioctl_wr with ioctl_addr < ROM_BYTES produces:
  - rom_we=1 for exactly 1 cycle, registered with 1-cycle latency.
  - rom_ad and rom_dt equal to the strobed address and data.
  - byte_count += 1, saturating at 2^25-1.
- LOAD, out of range: ioctl_wr with ioctl_addr >= ROM_BYTES gives no rom_we and sets load_err=1.
- Download end: a falling edge of ioctl_download while in LOAD moves to HOLD.
  - The hold counter loads HOLD_CYCLES-1.
  - If byte_count != ROM_BYTES, load_err=1.
  - An ioctl_wr in the same cycle as the falling edge is still accepted and counted before the compare.
- HOLD: the counter decrements each cycle. At 0 the block goes to RUN and sets load_done=1.
  - If load_err=1, the block goes to HALT instead, and load_done stays 0.
  - core_reset is therefore high for exactly HOLD_CYCLES cycles after the LOAD exit.
- RUN: user_rst=1 moves to HOLD and reloads the counter. user_rst held high keeps reloading, so core_reset stays high until HOLD_CYCLES after user_rst falls.
- user_rst in HALT or LOAD: no effect.
- Header download (index HDR_INDEX): an ioctl_wr with addr==0 latches sysmode. Other addresses are ignored. Allowed in any state; does not change state or core_reset.
- DIP download (index DSW_INDEX): an ioctl_wr with addr[24:3]==0 latches dsw byte addr[2:0]. Allowed in any state, including RUN, for live DIP changes. No reset.
- Other indices: ignored entirely.
- Asynchronous reset mid-download: all registers return to reset values, state HALT. Remaining writes from that download are ignored until the next download rise.
- rom_we is never asserted outside LOAD.

Decomposition:
- Package sys1_load_pkg holds:
  - the state enum (HALT, LOAD, HOLD, RUN);
  - default index constants ROM/HDR/DSW;
  - SYSMODE bit-position constants.
- One sub-module, sys1_reset_stretch: loadable down-counter with a busy output, parameterised by HOLD_CYCLES, used for the HOLD timing.

Test Plan:
- Power-up, no download: after reset deasserts -> core_reset=1, load_done=0, dsw=64'hFFFF_FFFF_FFFF_FFFF for 10,000 cycles.
- ROM load, ROM_BYTES=16, HOLD_CYCLES=4: 16 writes at addr 0..15 with data=addr^8'hA5, then download falls.
  - -> 16 rom_we pulses, each 1 cycle after its strobe, with matching ad/dt.
  - -> byte_count=16, core_reset high 4 cycles after the fall, then load_done=1, load_err=0.
- Short and overrange loads:
  - 15 writes -> load_err=1, state HALT, core_reset stays 1.
  - A write at addr 16 -> no rom_we for it, load_err=1.
- DIP/header while RUN: index 254 writes addr 3 = 8'h5C -> dsw[31:24]=8'h5C and core_reset stays 0. Index 1 addr 0 = 8'h06 -> sysmode=8'h06.
- user_rst in RUN, held 3 cycles -> core_reset high until 4 cycles after user_rst falls, then 0. load_done stays 1.
- Asynchronous reset at write 8 of 16, then a fresh full load -> outputs return to reset values immediately. The second load completes with byte_count=16, load_err=0.

Source files
------------

// File: rtl/sys1_load_pkg.sv
// rtl/sys1_load_pkg.sv - shared types and constants for the System 1 ROM loader
package sys1_load_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } load_state_e;

  localparam logic [7:0] ROM_INDEX_DEF = 8'd0;
  localparam logic [7:0] HDR_INDEX_DEF = 8'd1;
  localparam logic [7:0] DSW_INDEX_DEF = 8'd254;

  // SYSMODE header bit positions
  localparam int unsigned SYSMODE_SYS2_BIT = 0;
  localparam int unsigned SYSMODE_VERT_BIT = 1;
  localparam int unsigned SYSMODE_H240_BIT = 2;

endpackage

// File: rtl/sys1_reset_stretch.sv
// rtl/sys1_reset_stretch.sv - loadable down-counter timing the core reset hold
module sys1_reset_stretch #(
  parameter int unsigned HOLD_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy,
  output logic expire
);

  localparam logic [15:0] RELOAD = 16'(HOLD_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (load) begin
      cnt_d  = RELOAD;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == 16'd0) busy_d = 1'b0;
      else                cnt_d  = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 16'd0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // expire marks the final counted cycle so the owner leaves HOLD on time
  assign busy   = busy_q;
  assign expire = busy_q && (cnt_q == 16'd0);

endmodule

// File: rtl/sys1_rom_loader.sv
// rtl/sys1_rom_loader.sv - ioctl download sequencer and core reset owner for System 1
module sys1_rom_loader
  import sys1_load_pkg::*;
#(
  parameter logic [24:0] ROM_BYTES   = 25'h20000,
  parameter int unsigned HOLD_CYCLES = 256,
  parameter logic [7:0]  ROM_INDEX   = ROM_INDEX_DEF,
  parameter logic [7:0]  HDR_INDEX   = HDR_INDEX_DEF,
  parameter logic [7:0]  DSW_INDEX   = DSW_INDEX_DEF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        user_rst,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        rom_we,
  output logic [24:0] rom_ad,
  output logic [7:0]  rom_dt,
  output logic [7:0]  sysmode,
  output logic [63:0] dsw,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_err,
  output logic [24:0] byte_count
);

  load_state_e state_q, state_d;
  logic        dl_prev_q, active_q, active_d;
  logic [7:0]  idx_q, idx_d;
  logic        rom_we_q, rom_we_d;
  logic [24:0] rom_ad_q, rom_ad_d, byte_count_q, byte_count_d;
  logic [7:0]  rom_dt_q, rom_dt_d, sysmode_q, sysmode_d;
  logic [63:0] dsw_q, dsw_d;
  logic        core_reset_q, core_reset_d;
  logic        load_done_q, load_done_d, load_err_q, load_err_d;
  logic        dl_rise, dl_fall, rom_wr, stretch_load, stretch_busy, stretch_expire;

  sys1_reset_stretch #(.HOLD_CYCLES(HOLD_CYCLES)) u_stretch (
    .clk    (clk_sys),
    .rst    (reset),
    .load   (stretch_load),
    .busy   (stretch_busy),
    .expire (stretch_expire)
  );

  always_comb begin
    dl_rise      = ioctl_download && !dl_prev_q;
    dl_fall      = !ioctl_download && dl_prev_q;
    rom_wr       = (state_q == ST_LOAD) && ioctl_wr;
    state_d      = state_q;
    active_d     = active_q;
    idx_d        = idx_q;
    rom_we_d     = 1'b0;
    rom_ad_d     = rom_ad_q;
    rom_dt_d     = rom_dt_q;
    sysmode_d    = sysmode_q;
    dsw_d        = dsw_q;
    load_done_d  = load_done_q;
    load_err_d   = load_err_q;
    byte_count_d = byte_count_q;
    stretch_load = 1'b0;

    // The index is captured once per download; later changes are ignored
    if (dl_rise) begin
      active_d = 1'b1;
      idx_d    = ioctl_index;
    end else if (dl_fall) begin
      active_d = 1'b0;
    end

    if (active_q && ioctl_wr) begin
      if (idx_q == HDR_INDEX && ioctl_addr == 25'd0) sysmode_d = ioctl_dout;
      if (idx_q == DSW_INDEX && ioctl_addr[24:3] == 22'd0)
        dsw_d[{ioctl_addr[2:0], 3'b000} +: 8] = ioctl_dout;
    end

    if (rom_wr && ioctl_addr < ROM_BYTES) begin
      rom_we_d = 1'b1;
      rom_ad_d = ioctl_addr;
      rom_dt_d = ioctl_dout;
      if (byte_count_q != '1) byte_count_d = byte_count_q + 25'd1;
    end else if (rom_wr) begin
      load_err_d = 1'b1;
    end

    case (state_q)
      ST_LOAD: if (dl_fall) begin
        state_d      = ST_HOLD;
        stretch_load = 1'b1;
        if (byte_count_d != ROM_BYTES) load_err_d = 1'b1;
      end
      ST_HOLD: if (user_rst) begin
        stretch_load = 1'b1;
      end else if (stretch_expire || !stretch_busy) begin
        if (load_err_q) begin
          state_d = ST_HALT;
        end else begin
          state_d     = ST_RUN;
          load_done_d = 1'b1;
        end
      end
      ST_RUN: if (user_rst) begin
        state_d      = ST_HOLD;
        stretch_load = 1'b1;
      end
      default: ;
    endcase

    if (dl_rise && ioctl_index == ROM_INDEX) begin
      state_d      = ST_LOAD;
      byte_count_d = 25'd0;
      load_err_d   = 1'b0;
      load_done_d  = 1'b0;
    end

    core_reset_d = (state_d != ST_RUN);
  end

  // dl_prev resets high so a download still active across reset is not seen as a rise
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= ST_HALT;
      dl_prev_q    <= 1'b1;
      active_q     <= 1'b0;
      idx_q        <= 8'd0;
      rom_we_q     <= 1'b0;
      rom_ad_q     <= 25'd0;
      rom_dt_q     <= 8'd0;
      sysmode_q    <= 8'h00;
      dsw_q        <= '1;
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      byte_count_q <= 25'd0;
    end else begin
      state_q      <= state_d;
      dl_prev_q    <= ioctl_download;
      active_q     <= active_d;
      idx_q        <= idx_d;
      rom_we_q     <= rom_we_d;
      rom_ad_q     <= rom_ad_d;
      rom_dt_q     <= rom_dt_d;
      sysmode_q    <= sysmode_d;
      dsw_q        <= dsw_d;
      core_reset_q <= core_reset_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign rom_we     = rom_we_q;
  assign rom_ad     = rom_ad_q;
  assign rom_dt     = rom_dt_q;
  assign sysmode    = sysmode_q;
  assign dsw        = dsw_q;
  assign core_reset = core_reset_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_sys1_rom_loader.sv
// tb/tb_sys1_rom_loader.sv - self-checking bench for sys1_rom_loader
module tb_sys1_rom_loader;
  import sys1_load_pkg::*;

  localparam int ROMB = 16;
  localparam int HOLD = 4;

  logic        clk, rst, user_rst, ioctl_download, ioctl_wr;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic        rom_we, core_reset, load_done, load_err;
  logic [24:0] rom_ad, byte_count;
  logic [7:0]  rom_dt, sysmode;
  logic [63:0] dsw;

  int checks = 0;
  int errors = 0;

  sys1_rom_loader #(.ROM_BYTES(25'(ROMB)), .HOLD_CYCLES(HOLD)) dut (
    .clk_sys(clk), .reset(rst), .user_rst(user_rst),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .rom_we(rom_we), .rom_ad(rom_ad), .rom_dt(rom_dt), .sysmode(sysmode), .dsw(dsw),
    .core_reset(core_reset), .load_done(load_done), .load_err(load_err),
    .byte_count(byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  idx;
    logic [24:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp_sysmode;
    logic [63:0] exp_dsw;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic rise(input logic [7:0] idx);
    ioctl_download = 1'b1;
    ioctl_index    = idx;
    tick();
  endtask

  task automatic fall();
    ioctl_download = 1'b0;
    tick();
  endtask

  // One byte strobe; optionally coincident with the download fall
  task automatic strobe(input logic [24:0] a, input logic [7:0] d, input bit with_fall,
                        input bit exp_we, input int gap);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (with_fall) ioctl_download = 1'b0;
    tick();
    ioctl_wr = 1'b0;
    check("rom_we", 64'(rom_we), 64'(exp_we));
    if (exp_we) begin
      check("rom_ad", 64'(rom_ad), 64'(a));
      check("rom_dt", 64'(rom_dt), 64'(d));
    end
    for (int g = 0; g < gap; g++) begin
      tick();
      check("rom_we_width", 64'(rom_we), 64'd0);
    end
  endtask

  task automatic measure(input int bound, output int n);
    n = 0;
    while (core_reset === 1'b1 && n < bound) begin
      n++;
      tick();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_core_reset"}, 64'(core_reset), 64'd1);
    check({tag, "_rom_we"}, 64'(rom_we), 64'd0);
    check({tag, "_rom_ad"}, 64'(rom_ad), 64'd0);
    check({tag, "_rom_dt"}, 64'(rom_dt), 64'd0);
    check({tag, "_sysmode"}, 64'(sysmode), 64'd0);
    check({tag, "_dsw"}, dsw, 64'hFFFF_FFFF_FFFF_FFFF);
    check({tag, "_load_done"}, 64'(load_done), 64'd0);
    check({tag, "_load_err"}, 64'(load_err), 64'd0);
    check({tag, "_byte_count"}, 64'(byte_count), 64'd0);
  endtask

  logic [7:0]  m_dsw[8];
  logic [63:0] m_packed;
  logic [24:0] a;
  logic [7:0]  d;
  int          n, bad, cnt, nw;
  bit          err, full, fw, last;

  initial begin
    vecs[0] = '{DSW_INDEX_DEF, 25'd3, 8'h5C, 8'h00, 64'hFFFF_FFFF_5CFF_FFFF};
    vecs[1] = '{HDR_INDEX_DEF, 25'd0, 8'h06,
                8'((1 << SYSMODE_VERT_BIT) | (1 << SYSMODE_H240_BIT)), 64'hFFFF_FFFF_5CFF_FFFF};
    vecs[2] = '{HDR_INDEX_DEF, 25'd1, 8'h77, 8'h06, 64'hFFFF_FFFF_5CFF_FFFF};
    vecs[3] = '{DSW_INDEX_DEF, 25'd8, 8'h11, 8'h06, 64'hFFFF_FFFF_5CFF_FFFF};
    vecs[4] = '{DSW_INDEX_DEF, 25'd0, 8'h12, 8'h06, 64'hFFFF_FFFF_5CFF_FF12};
    vecs[5] = '{DSW_INDEX_DEF, 25'd7, 8'hA0, 8'h06, 64'hA0FF_FFFF_5CFF_FF12};
    vecs[6] = '{8'd7, 25'd0, 8'h33, 8'(1 << SYSMODE_SYS2_BIT) ^ 8'h07, 64'hA0FF_FFFF_5CFF_FF12};

    rst = 1'b1; user_rst = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_index = 8'd0; ioctl_addr = 25'd0; ioctl_dout = 8'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_reset_vals("por");

    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (core_reset !== 1'b1 || load_done !== 1'b0 || dsw !== 64'hFFFF_FFFF_FFFF_FFFF) bad++;
    end
    check("powerup_hold", 64'(bad), 64'd0);

    // Full load; index changed to the header index mid-download must be ignored
    rise(ROM_INDEX_DEF);
    ioctl_index = HDR_INDEX_DEF;
    for (int i = 0; i < ROMB; i++) strobe(25'(i), 8'(i) ^ 8'hA5, 1'b0, 1'b1, 1);
    fall();
    check("full_byte_count", 64'(byte_count), 64'(ROMB));
    check("full_load_err", 64'(load_err), 64'd0);
    check("full_idx_sampled", 64'(sysmode), 64'd0);
    measure(50, n);
    check("full_hold_len", 64'(n), 64'(HOLD));
    check("full_load_done", 64'(load_done), 64'd1);

    for (int v = 0; v < 7; v++) begin
      rise(vecs[v].idx);
      strobe(vecs[v].addr, vecs[v].data, 1'b0, 1'b0, 0);
      fall();
      check("vec_sysmode", 64'(sysmode), 64'(vecs[v].exp_sysmode));
      check("vec_dsw", dsw, vecs[v].exp_dsw);
      check("vec_core_reset", 64'(core_reset), 64'd0);
    end

    user_rst = 1'b1;
    tick();
    check("urst_assert", 64'(core_reset), 64'd1);
    tick(); tick();
    user_rst = 1'b0;
    measure(50, n);
    check("urst_hold_len", 64'(n), 64'(HOLD));
    check("urst_load_done", 64'(load_done), 64'd1);

    rise(ROM_INDEX_DEF);
    for (int i = 0; i < ROMB - 1; i++) strobe(25'(i), 8'(i), 1'b0, 1'b1, 1);
    fall();
    check("short_byte_count", 64'(byte_count), 64'(ROMB - 1));
    check("short_load_err", 64'(load_err), 64'd1);
    measure(20, n);
    check("short_halt", 64'(n), 64'd20);
    check("short_load_done", 64'(load_done), 64'd0);

    rise(ROM_INDEX_DEF);
    for (int i = 0; i < 8; i++) strobe(25'(i), 8'(i), 1'b0, 1'b1, 1);
    check("over_err_clear", 64'(load_err), 64'd0);
    strobe(25'(ROMB), 8'h3C, 1'b0, 1'b0, 1);
    check("over_err_set", 64'(load_err), 64'd1);
    for (int i = 8; i < ROMB; i++) strobe(25'(i), 8'(i), 1'b0, 1'b1, 1);
    fall();
    check("over_byte_count", 64'(byte_count), 64'(ROMB));
    measure(20, n);
    check("over_halt", 64'(n), 64'd20);

    // Asynchronous reset during write 8 of 16
    rise(ROM_INDEX_DEF);
    for (int i = 0; i < 8; i++) strobe(25'(i), 8'(i) ^ 8'h5A, 1'b0, 1'b1, 1);
    ioctl_wr = 1'b1; ioctl_addr = 25'd8; ioctl_dout = 8'h99;
    #2 rst = 1'b1;
    #1 check_reset_vals("async");
    tick();
    ioctl_wr = 1'b0;
    rst = 1'b0;
    for (int i = 9; i < ROMB; i++) strobe(25'(i), 8'(i), 1'b0, 1'b0, 1);
    fall();
    check("async_ignored_count", 64'(byte_count), 64'd0);
    check("async_core_reset", 64'(core_reset), 64'd1);
    rise(ROM_INDEX_DEF);
    for (int i = 0; i < ROMB; i++) strobe(25'(i), 8'(i) ^ 8'hC3, i == ROMB - 1, 1'b1, (i == ROMB - 1) ? 0 : 1);
    check("fresh_byte_count", 64'(byte_count), 64'(ROMB));
    check("fresh_load_err", 64'(load_err), 64'd0);
    measure(50, n);
    check("fresh_hold_len", 64'(n), 64'(HOLD));
    check("fresh_load_done", 64'(load_done), 64'd1);

    // Randomized loads and DIP writes against a count/range model
    for (int k = 0; k < 8; k++) m_dsw[k] = 8'hFF;
    for (int t = 0; t < 10; t++) begin
      full = 1'($urandom_range(0, 1));
      nw   = full ? ROMB : int'($urandom_range(10, 20));
      fw   = 1'($urandom_range(0, 1));
      rise(ROM_INDEX_DEF);
      ioctl_index = 8'($urandom);
      cnt = 0;
      err = 1'b0;
      for (int i = 0; i < nw; i++) begin
        a    = full ? 25'(i) : 25'($urandom_range(0, 19));
        d    = 8'($urandom);
        last = fw && (i == nw - 1);
        user_rst = last ? 1'b0 : 1'($urandom_range(0, 1));
        if (a < 25'(ROMB)) cnt++;
        else err = 1'b1;
        strobe(a, d, last, a < 25'(ROMB), last ? 0 : int'($urandom_range(0, 2)));
      end
      user_rst = 1'b0;
      if (!fw) fall();
      if (cnt != ROMB) err = 1'b1;
      check("rnd_byte_count", 64'(byte_count), 64'(cnt));
      check("rnd_load_err", 64'(load_err), 64'(err));
      measure(20, n);
      check("rnd_hold_len", 64'(n), err ? 64'd20 : 64'(HOLD));
      check("rnd_load_done", 64'(load_done), 64'(!err));

      a = 25'($urandom_range(0, 11));
      d = 8'($urandom);
      rise(DSW_INDEX_DEF);
      strobe(a, d, 1'b0, 1'b0, 0);
      fall();
      if (a < 25'd8) m_dsw[a[2:0]] = d;
      for (int k = 0; k < 8; k++) m_packed[8*k +: 8] = m_dsw[k];
      check("rnd_dsw", dsw, m_packed);
      check("rnd_dsw_core_reset", 64'(core_reset), 64'(err));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
